// File: rtl/instr_mem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory.
// Ports: Start/Stop session control, Word_* handshake, Mem_Write_* byte port, status.
module instr_mem_loader #(
  parameter int MEM_BYTES = 16,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Base_Address,
  input  logic              Stop,
  input  logic              Word_Valid,
  input  logic [31:0]       Word_In,
  output logic              Word_Ready,
  output logic              Mem_Write_Enable,
  output logic [ADDR_W-1:0] Mem_Write_Address,
  output logic [7:0]        Mem_Write_Data,
  output logic [31:0]       Words_Loaded,
  output logic              Busy,
  output logic              Done,
  output logic              Overflow
);

  typedef enum logic [2:0] {
    IDLE, ARMED, B0, B1, B2, B3, FULL
  } state_t;

  localparam logic [ADDR_W-1:0] MEM_END = ADDR_W'(MEM_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_M = ~ADDR_W'(3);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [31:0]       word_q, word_d;
  logic              stop_q, stop_d;
  logic [31:0]       wl_q, wl_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;

  logic [ADDR_W-1:0] base_al;
  logic              accept;
  logic [1:0]        k;

  assign base_al = Base_Address & ALIGN_M;
  assign accept  = Word_Valid && rdy_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    word_d  = word_q;
    stop_d  = stop_q;
    wl_d    = wl_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (Start) begin
          ptr_d   = base_al;
          wl_d    = '0;
          ovf_d   = 1'b0;
          state_d = (base_al >= MEM_END) ? FULL : ARMED;
        end
      end
      ARMED: begin
        if (Start) begin
          ptr_d   = base_al;
          wl_d    = '0;
          ovf_d   = 1'b0;
          stop_d  = 1'b0;
          state_d = (base_al >= MEM_END) ? FULL : ARMED;
        end else if (accept) begin
          // a Stop arriving with the word waits for it to finish
          word_d  = Word_In;
          stop_d  = Stop;
          state_d = B0;
        end else if (Stop) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      B0: begin
        stop_d  = stop_q | Stop;
        state_d = B1;
      end
      B1: begin
        stop_d  = stop_q | Stop;
        state_d = B2;
      end
      B2: begin
        stop_d  = stop_q | Stop;
        state_d = B3;
      end
      B3: begin
        wl_d   = (wl_q == '1) ? wl_q : wl_q + 32'd1;
        ptr_d  = ptr_q + ADDR_W'(4);
        stop_d = 1'b0;
        if (stop_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (ptr_q + ADDR_W'(4) == MEM_END) begin
          state_d = FULL;
        end else if (accept) begin
          word_d  = Word_In;
          stop_d  = Stop;
          state_d = B0;
        end else if (Stop) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = ARMED;
        end
      end
      FULL: begin
        if (Word_Valid) ovf_d = 1'b1;
        if (Start) begin
          ptr_d   = base_al;
          wl_d    = '0;
          ovf_d   = 1'b0;
          stop_d  = 1'b0;
          state_d = (base_al >= MEM_END) ? FULL : ARMED;
        end else if (Stop) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next state.
  always_comb begin
    k      = 2'd0;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    unique case (state_d)
      B0:      begin k = 2'd0; we_d = 1'b1; end
      B1:      begin k = 2'd1; we_d = 1'b1; end
      B2:      begin k = 2'd2; we_d = 1'b1; end
      B3:      begin k = 2'd3; we_d = 1'b1; end
      default: k = 2'd0;
    endcase
    if (we_d) begin
      addr_d = ptr_d + ADDR_W'(k);
      data_d = word_d[{k, 3'b000} +: 8];
    end
    // B3 can take the next word unless this word fills memory or a Stop waits
    rdy_d  = (state_d == ARMED) ||
             (state_d == B3 && !stop_d &&
              (ptr_d + ADDR_W'(4) != MEM_END));
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      word_q  <= '0;
      stop_q  <= 1'b0;
      wl_q    <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      word_q  <= word_d;
      stop_q  <= stop_d;
      wl_q    <= wl_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign Word_Ready        = rdy_q;
  assign Mem_Write_Enable  = we_q;
  assign Mem_Write_Address = addr_q;
  assign Mem_Write_Data    = data_q;
  assign Words_Loaded      = wl_q;
  assign Busy              = busy_q;
  assign Done              = done_q;
  assign Overflow          = ovf_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed testbench for instr_mem_loader.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_instr_mem_loader;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [63:0] Base_Address;
  logic        Stop;
  logic        Word_Valid;
  logic [31:0] Word_In;
  logic        Word_Ready;
  logic        Mem_Write_Enable;
  logic [63:0] Mem_Write_Address;
  logic [7:0]  Mem_Write_Data;
  logic [31:0] Words_Loaded;
  logic        Busy;
  logic        Done;
  logic        Overflow;

  int checks;
  int errors;

  instr_mem_loader #(.MEM_BYTES(16), .ADDR_W(64)) dut (
    .clk(clk),
    .reset(reset),
    .Start(Start),
    .Base_Address(Base_Address),
    .Stop(Stop),
    .Word_Valid(Word_Valid),
    .Word_In(Word_In),
    .Word_Ready(Word_Ready),
    .Mem_Write_Enable(Mem_Write_Enable),
    .Mem_Write_Address(Mem_Write_Address),
    .Mem_Write_Data(Mem_Write_Data),
    .Words_Loaded(Words_Loaded),
    .Busy(Busy),
    .Done(Done),
    .Overflow(Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({Word_Ready, Mem_Write_Enable, Busy, Done, Overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 00000",
               {Word_Ready, Mem_Write_Enable, Busy, Done, Overflow});
    end
    checks++;
    if ({Mem_Write_Address, Mem_Write_Data, Words_Loaded} !== 104'h0) begin
      errors++;
      $display("FAIL reset_regs addr %0h data %0h wl %0d exp 0",
               Mem_Write_Address, Mem_Write_Data, Words_Loaded);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    logic [7:0] exp_b [4];
    exp_b = '{8'h83, 8'h34, 8'h85, 8'h02};
    Start = 1'b1; Base_Address = 64'd0;
    @(negedge clk);
    Start = 1'b0;
    checks++;
    if ({Word_Ready, Busy, Mem_Write_Enable} !== 3'b110) begin
      errors++;
      $display("FAIL single_armed got %b exp 110",
               {Word_Ready, Busy, Mem_Write_Enable});
    end
    Word_Valid = 1'b1; Word_In = 32'h02853483;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      Word_Valid = 1'b0;
      checks++;
      if ({Mem_Write_Enable, Mem_Write_Address, Mem_Write_Data} !==
          {1'b1, 64'(k), exp_b[k]}) begin
        errors++;
        $display("FAIL single_byte%0d got we=%b a=%0h d=%0h exp we=1 a=%0h d=%0h",
                 k, Mem_Write_Enable, Mem_Write_Address, Mem_Write_Data,
                 k, exp_b[k]);
      end
    end
    @(negedge clk);
    checks++;
    if ({Mem_Write_Enable, Word_Ready, Words_Loaded} !== {2'b01, 32'd1}) begin
      errors++;
      $display("FAIL single_after we=%b rdy=%b wl=%0d exp we=0 rdy=1 wl=1",
               Mem_Write_Enable, Word_Ready, Words_Loaded);
    end
    Stop = 1'b1;
    @(negedge clk);
    Stop = 1'b0;
    checks++;
    if ({Done, Busy, Word_Ready} !== 3'b100) begin
      errors++;
      $display("FAIL single_stop done/busy/rdy got %b exp 100",
               {Done, Busy, Word_Ready});
    end
    @(negedge clk);
    checks++;
    if (Done !== 1'b0) begin
      errors++;
      $display("FAIL single_done_pulse got %b exp 0", Done);
    end
  endtask

  task automatic test_fill_memory();
    logic [31:0] w [4];
    w = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    Start = 1'b1; Base_Address = 64'd0;
    @(negedge clk);
    Start = 1'b0;
    Word_Valid = 1'b1; Word_In = w[0];
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if ({Mem_Write_Enable, Mem_Write_Address, Mem_Write_Data} !==
          {1'b1, 64'(i), 8'(i)}) begin
        errors++;
        $display("FAIL fill_strobe%0d got we=%b a=%0h d=%0h exp we=1 a=%0h d=%0h",
                 i, Mem_Write_Enable, Mem_Write_Address, Mem_Write_Data, i, i);
      end
      if (i % 4 == 3) begin
        if (i < 15) Word_In = w[i / 4 + 1];
        else Word_In = 32'hFFFFFFFF;
      end
    end
    @(negedge clk);
    checks++;
    if ({Mem_Write_Enable, Word_Ready, Busy, Overflow, Words_Loaded} !==
        {4'b0010, 32'd4}) begin
      errors++;
      $display("FAIL fill_full we/rdy/busy/ovf=%b wl=%0d exp 0010 wl=4",
               {Mem_Write_Enable, Word_Ready, Busy, Overflow}, Words_Loaded);
    end
    @(negedge clk);
    Word_Valid = 1'b0;
    checks++;
    if ({Overflow, Mem_Write_Enable} !== 2'b10) begin
      errors++;
      $display("FAIL fill_overflow ovf/we got %b exp 10",
               {Overflow, Mem_Write_Enable});
    end
    Stop = 1'b1;
    @(negedge clk);
    Stop = 1'b0;
    checks++;
    if ({Done, Busy, Overflow} !== 3'b101) begin
      errors++;
      $display("FAIL fill_stop done/busy/ovf got %b exp 101",
               {Done, Busy, Overflow});
    end
    @(negedge clk);
  endtask

  task automatic test_misaligned_base();
    logic [7:0] exp_b [4];
    exp_b = '{8'hB3, 8'h84, 8'h9A, 8'h00};
    Start = 1'b1; Base_Address = 64'd6;
    @(negedge clk);
    Start = 1'b0;
    checks++;
    if ({Overflow, Words_Loaded} !== 33'd0) begin
      errors++;
      $display("FAIL misal_clear ovf=%b wl=%0d exp 0 0", Overflow, Words_Loaded);
    end
    Word_Valid = 1'b1; Word_In = 32'h009A84B3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      Word_Valid = 1'b0;
      checks++;
      if ({Mem_Write_Enable, Mem_Write_Address, Mem_Write_Data} !==
          {1'b1, 64'(4 + k), exp_b[k]}) begin
        errors++;
        $display("FAIL misal_byte%0d got we=%b a=%0h d=%0h exp we=1 a=%0h d=%0h",
                 k, Mem_Write_Enable, Mem_Write_Address, Mem_Write_Data,
                 4 + k, exp_b[k]);
      end
    end
    @(negedge clk);
    Stop = 1'b1;
    @(negedge clk);
    Stop = 1'b0;
    checks++;
    if ({Done, Busy, Words_Loaded} !== {2'b10, 32'd1}) begin
      errors++;
      $display("FAIL misal_stop done=%b busy=%b wl=%0d exp 1 0 1",
               Done, Busy, Words_Loaded);
    end
    @(negedge clk);
  endtask

  task automatic test_stop_during_write();
    logic [7:0] exp_b [4];
    exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    Start = 1'b1; Base_Address = 64'd0;
    @(negedge clk);
    Start = 1'b0;
    Word_Valid = 1'b1; Word_In = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      Word_Valid = 1'b0;
      Stop = (k == 1);
      checks++;
      if ({Mem_Write_Enable, Mem_Write_Address, Mem_Write_Data, Done} !==
          {1'b1, 64'(k), exp_b[k], 1'b0}) begin
        errors++;
        $display("FAIL stopw_byte%0d got we=%b a=%0h d=%0h done=%b exp 1 %0h %0h 0",
                 k, Mem_Write_Enable, Mem_Write_Address, Mem_Write_Data, Done,
                 k, exp_b[k]);
      end
      if (k >= 2) begin
        checks++;
        if (Word_Ready !== 1'b0) begin
          errors++;
          $display("FAIL stopw_ready%0d got %b exp 0", k, Word_Ready);
        end
      end
    end
    @(negedge clk);
    checks++;
    if ({Done, Busy, Word_Ready, Mem_Write_Enable, Words_Loaded} !==
        {4'b1000, 32'd1}) begin
      errors++;
      $display("FAIL stopw_done done/busy/rdy/we=%b wl=%0d exp 1000 wl=1",
               {Done, Busy, Word_Ready, Mem_Write_Enable}, Words_Loaded);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_word();
    Start = 1'b1; Base_Address = 64'd0;
    @(negedge clk);
    Start = 1'b0;
    Word_Valid = 1'b1; Word_In = 32'h11223344;
    repeat (3) @(negedge clk);
    Word_Valid = 1'b0;
    checks++;
    if ({Mem_Write_Enable, Mem_Write_Address, Mem_Write_Data} !==
        {1'b1, 64'd2, 8'h22}) begin
      errors++;
      $display("FAIL rstmid_b2 got we=%b a=%0h d=%0h exp 1 2 22",
               Mem_Write_Enable, Mem_Write_Address, Mem_Write_Data);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if ({Mem_Write_Enable, Busy, Word_Ready, Words_Loaded, Mem_Write_Address} !==
        {3'b000, 32'd0, 64'd0}) begin
      errors++;
      $display("FAIL rstmid_after we/busy/rdy=%b wl=%0d a=%0h exp 000 0 0",
               {Mem_Write_Enable, Busy, Word_Ready}, Words_Loaded,
               Mem_Write_Address);
    end
    @(negedge clk);
    checks++;
    if (Mem_Write_Enable !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_nostrobe got %b exp 0", Mem_Write_Enable);
    end
    Start = 1'b1; Base_Address = 64'd0;
    @(negedge clk);
    Start = 1'b0;
    Word_Valid = 1'b1; Word_In = 32'h55667788;
    @(negedge clk);
    Word_Valid = 1'b0;
    checks++;
    if ({Mem_Write_Enable, Mem_Write_Address, Mem_Write_Data} !==
        {1'b1, 64'd0, 8'h88}) begin
      errors++;
      $display("FAIL rstmid_restart got we=%b a=%0h d=%0h exp 1 0 88",
               Mem_Write_Enable, Mem_Write_Address, Mem_Write_Data);
    end
    repeat (4) @(negedge clk);
    Stop = 1'b1;
    @(negedge clk);
    Stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_restart_armed();
    Start = 1'b1; Base_Address = 64'd0;
    @(negedge clk);
    Base_Address = 64'd8;
    @(negedge clk);
    Start = 1'b0;
    checks++;
    if ({Done, Word_Ready, Busy} !== 3'b011) begin
      errors++;
      $display("FAIL restart_state done/rdy/busy got %b exp 011",
               {Done, Word_Ready, Busy});
    end
    Word_Valid = 1'b1; Word_In = 32'hA1B2C3D4;
    @(negedge clk);
    Word_Valid = 1'b0;
    checks++;
    if ({Mem_Write_Enable, Mem_Write_Address, Mem_Write_Data} !==
        {1'b1, 64'd8, 8'hD4}) begin
      errors++;
      $display("FAIL restart_addr got we=%b a=%0h d=%0h exp 1 8 d4",
               Mem_Write_Enable, Mem_Write_Address, Mem_Write_Data);
    end
    repeat (4) @(negedge clk);
    Stop = 1'b1;
    @(negedge clk);
    Stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_base_out_of_range();
    Start = 1'b1; Base_Address = 64'd16;
    @(negedge clk);
    Start = 1'b0;
    checks++;
    if ({Busy, Word_Ready, Mem_Write_Enable} !== 3'b100) begin
      errors++;
      $display("FAIL oor_full busy/rdy/we got %b exp 100",
               {Busy, Word_Ready, Mem_Write_Enable});
    end
    Stop = 1'b1;
    @(negedge clk);
    Stop = 1'b0;
    checks++;
    if ({Done, Busy} !== 2'b10) begin
      errors++;
      $display("FAIL oor_stop done/busy got %b exp 10", {Done, Busy});
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    Start = 1'b0;
    Base_Address = '0;
    Stop = 1'b0;
    Word_Valid = 1'b0;
    Word_In = '0;
    test_reset();
    test_single_word();
    test_fill_memory();
    test_misaligned_base();
    test_stop_during_write();
    test_reset_mid_word();
    test_restart_armed();
    test_base_out_of_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Write-side companion to the byte-addressed, little-endian instruction memory.
- Accepts 32-bit instruction words over a valid/ready handshake and streams them into the memory as four byte writes: byte k goes to address A+k and takes bits [8k+7:8k].
- Used at boot or test time to program the instruction store before the fetch path reads it back.

Parameters:
- MEM_BYTES, 16, size of the target instruction memory in bytes; a multiple of 4.
- ADDR_W, 64, width of the memory byte-address bus; matches the instruction-address width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- Start  in  1  single-cycle pulse that opens a load session at Base_Address.
- Base_Address  in  ADDR_W  first byte address of the session; bits [1:0] are forced to 0.
- Stop  in  1  single-cycle pulse that closes the session.
- Word_Valid  in  1  Word_In holds a valid instruction.
- Word_In  in  32  instruction to store.
- Word_Ready  out  1  loader can accept a word this cycle.
- Mem_Write_Enable  out  1  byte write strobe to the memory.
- Mem_Write_Address  out  ADDR_W  byte address of the write.
- Mem_Write_Data  out  8  byte to write.
- Words_Loaded  out  32  words fully written in the current session.
- Busy  out  1  a session is open (state is not IDLE).
- Done  out  1  one-cycle pulse when a session closes.
- Overflow  out  1  sticky flag: a word was offered while the memory was full.

Behaviour:
- All outputs are registered.
- Reset (reset=0 at a clock edge) forces:
  - state IDLE;
  - Word_Ready, Mem_Write_Enable, Busy, Done and Overflow to 0;
  - Mem_Write_Address, Mem_Write_Data and Words_Loaded to 0.
- Reset mid-word aborts the word. Bytes already written stay in memory; there are no further strobes.
- States: IDLE, ARMED, B0, B1, B2, B3, FULL.
- IDLE:
  - Word_Ready=0.
  - Start → latch ptr = {Base_Address[ADDR_W-1:2], 2'b00}, clear Words_Loaded and Overflow.
  - Go to FULL if ptr >= MEM_BYTES, else to ARMED.
- ARMED:
  - Word_Ready=1.
  - Word_Valid&&Word_Ready at edge N → latch Word_In, go to B0.
  - Byte 0 is driven during cycle N+1, byte 1 during N+2, byte 2 during N+3, byte 3 during N+4.
- Bk, for k=0..3:
  - Mem_Write_Enable=1, Mem_Write_Address=ptr+k, Mem_Write_Data=word[8k+7:8k].
  - B0 → B1 → B2 → B3 unconditionally.
- Completion at the end of B3:
  - Words_Loaded += 1 and ptr += 4.
  - If ptr+4 == MEM_BYTES, go to FULL.
  - Otherwise Word_Ready=1 during B3, so a word accepted at the end of B3 goes straight to B0. Sustained throughput is 1 word per 4 cycles.
- Mem_Write_Enable=0 in every state other than Bk. Address and data hold their last values when not writing.
- FULL:
  - Word_Ready=0.
  - Word_Valid=1 sets Overflow; Overflow stays set until the next Start or reset.
- Stop:
  - In ARMED or FULL: go to IDLE and pulse Done for 1 cycle.
  - During B0..B3: deferred; the word completes, then the loader goes to IDLE (not ARMED or FULL) with the Done pulse.
  - In IDLE: ignored.
  - Stop and a word accept in the same ARMED cycle: the word is accepted and the Stop is deferred.
- Start:
  - Honoured only in IDLE, ARMED and FULL; ignored during B0..B3.
  - Start in ARMED or FULL restarts the session (reload ptr, clear Words_Loaded and Overflow) with no Done pulse.
  - Start and Stop together: Start wins.
- Busy=1 in every state except IDLE.
- Words_Loaded saturates at 2^32-1; it never wraps.
- Address arithmetic is unsigned and ADDR_W wide.

Test Plan:
- Single word: Start with Base=0; one word 0x02853483; Stop. → Byte writes (0,0x83), (1,0x34), (2,0x85), (3,0x02) on 4 consecutive cycles after the accept; Words_Loaded=1; Done pulses once; Busy drops.
- Fill memory: Start with Base=0; 4 back-to-back words with Word_Valid held high. → 16 strobes on 16 consecutive cycles, addresses 0..15; FULL reached; Word_Ready=0; a 5th Word_Valid sets Overflow=1 and produces no strobe.
- Misaligned base: Start with Base=6; one word 0x009A84B3. → Writes go to addresses 4..7 with bytes B3,84,9A,00.
- Stop during write: Stop pulsed in B1. → All 4 bytes still written; Done on the cycle after B3; Word_Ready stays 0.
- Reset during B2: reset=0 for 1 cycle. → Mem_Write_Enable=0 on the next cycle; Words_Loaded=0; state IDLE; a following Start works normally.
- Base out of range: Start with Base=16. → Goes directly to FULL; Word_Ready=0; Stop gives IDLE and a Done pulse.
